// File: rtl/game_pkg.sv
// game_pkg: choice codes, FSM state encoding and win table for the choice game.
package game_pkg;

    localparam logic [2:0] CAT     = 3'b001;
    localparam logic [2:0] DOG     = 3'b010;
    localparam logic [2:0] CHICKEN = 3'b100;

    typedef enum logic [2:0] {
        WAIT_P1,
        WAIT_P2,
        RESOLVE,
        SHOW,
        OVER
    } state_t;

    function automatic logic is_choice(input logic [2:0] c);
        return (c == CAT) || (c == DOG) || (c == CHICKEN);
    endfunction

    function automatic logic [3:0] choice_idx(input logic [2:0] c);
        return c[0] ? 4'd0 : c[1] ? 4'd1 : 4'd2;
    endfunction

    function automatic logic beats(input logic [2:0] a, input logic [2:0] b);
        return (a == DOG && b == CAT) || (a == CAT && b == CHICKEN) || (a == CHICKEN && b == DOG);
    endfunction

    // Bit (8 - idx) is the same as shifting the top bit right by idx.
    function automatic logic [8:0] scenario_code(input logic [2:0] a, input logic [2:0] b);
        return 9'b1_0000_0000 >> (choice_idx(a) * 4'd3 + choice_idx(b));
    endfunction

endpackage

// File: rtl/key_edge.sv
// key_edge: 2-FF synchronizer plus rising-edge detector for an asynchronous key level.
module key_edge (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic pulse
);
    logic s1, s2, prev, armed;
    logic [1:0] fill;

    // Only arm once the synchronized key has genuinely been seen low, so a key
    // held through reset does not register as a press.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            prev  <= 1'b0;
            armed <= 1'b0;
            fill  <= 2'b00;
        end else begin
            s1    <= d;
            s2    <= s1;
            prev  <= s2;
            fill  <= {fill[0], 1'b1};
            armed <= armed | (fill[1] & ~s2);
        end
    end

    assign pulse = s2 & ~prev & armed;

endmodule

// File: rtl/choice_arbiter.sv
// choice_arbiter: two-player cat/dog/chicken match referee with score keeping.
module choice_arbiter
    import game_pkg::*;
#(
    parameter logic [3:0] WIN_SCORE = 4'd5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] sw,
    input  logic       choose,
    input  logic       cont,
    input  logic       reset_game,
    output logic [8:0] scenario,
    output logic       scenario_valid,
    output logic       winner1,
    output logic       winner2,
    output logic       tie,
    output logic [3:0] player1,
    output logic [3:0] player2,
    output logic       match_over,
    output logic       invalid,
    output logic       turn
);
    state_t state, nxt;
    logic [2:0] p1, p2;
    logic ch_e, co_e, rg_e;
    logic inv_n, w1, w2, done;
    logic [3:0] p1_n, p2_n;

    key_edge u_choose (.clk(clk), .resetn(resetn), .d(choose),     .pulse(ch_e));
    key_edge u_cont   (.clk(clk), .resetn(resetn), .d(cont),       .pulse(co_e));
    key_edge u_reset  (.clk(clk), .resetn(resetn), .d(reset_game), .pulse(rg_e));

    assign w1   = beats(p1, p2);
    assign w2   = beats(p2, p1);
    assign p1_n = (w1 && player1 != 4'd9) ? player1 + 4'd1 : player1;
    assign p2_n = (w2 && player2 != 4'd9) ? player2 + 4'd1 : player2;
    assign done = (w1 && p1_n == WIN_SCORE) || (w2 && p2_n == WIN_SCORE);

    assign turn           = state == WAIT_P2;
    assign match_over     = state == OVER;
    assign scenario_valid = state == SHOW || state == OVER;

    always_comb begin
        nxt   = state;
        inv_n = 1'b0;
        if (rg_e) nxt = WAIT_P1;
        else begin
            case (state)
                WAIT_P1: begin
                    nxt   = (ch_e && is_choice(sw)) ? WAIT_P2 : WAIT_P1;
                    inv_n = ch_e && !is_choice(sw);
                end
                WAIT_P2: begin
                    nxt   = (ch_e && is_choice(sw)) ? RESOLVE : WAIT_P2;
                    inv_n = ch_e && !is_choice(sw);
                end
                RESOLVE: nxt = done ? OVER : SHOW;
                SHOW:    nxt = co_e ? WAIT_P1 : SHOW;
                OVER:    nxt = OVER;
                default: nxt = WAIT_P1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= WAIT_P1;
            invalid  <= 1'b0;
            p1       <= 3'b000;
            p2       <= 3'b000;
            scenario <= 9'd0;
            winner1  <= 1'b0;
            winner2  <= 1'b0;
            tie      <= 1'b0;
            player1  <= 4'd0;
            player2  <= 4'd0;
        end else begin
            state   <= nxt;
            invalid <= inv_n;
            if (rg_e) begin
                p1       <= 3'b000;
                p2       <= 3'b000;
                scenario <= 9'd0;
                winner1  <= 1'b0;
                winner2  <= 1'b0;
                tie      <= 1'b0;
                player1  <= 4'd0;
                player2  <= 4'd0;
            end else begin
                if (state == WAIT_P1 && ch_e && is_choice(sw)) p1 <= sw;
                if (state == WAIT_P2 && ch_e && is_choice(sw)) p2 <= sw;
                if (state == RESOLVE) begin
                    scenario <= scenario_code(p1, p2);
                    winner1  <= w1;
                    winner2  <= w2;
                    tie      <= p1 == p2;
                    player1  <= p1_n;
                    player2  <= p2_n;
                end
                if (state == SHOW && co_e) begin
                    scenario <= 9'd0;
                    winner1  <= 1'b0;
                    winner2  <= 1'b0;
                    tie      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_choice_arbiter.sv
// tb_choice_arbiter: table-driven, hand-written and randomized checks of choice_arbiter.
module tb_choice_arbiter;
    localparam int WIN = 5;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [2:0] sw = 3'b000;
    logic       choose = 1'b0, cont = 1'b0, reset_game = 1'b0;
    logic [8:0] scenario;
    logic       scenario_valid, winner1, winner2, tie, match_over, invalid, turn;
    logic [3:0] player1, player2;

    int n_cmp = 0;
    int n_bad = 0;
    int inv_cnt = 0;

    choice_arbiter #(.WIN_SCORE(4'd5)) dut (
        .clk(clk), .resetn(resetn), .sw(sw), .choose(choose), .cont(cont),
        .reset_game(reset_game), .scenario(scenario), .scenario_valid(scenario_valid),
        .winner1(winner1), .winner2(winner2), .tie(tie), .player1(player1),
        .player2(player2), .match_over(match_over), .invalid(invalid), .turn(turn)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (invalid) inv_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] a, b;
        logic [8:0] scen;
        logic       w1, w2, t;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic press(input int which);
        @(negedge clk);
        if (which == 0) choose = 1'b1; else if (which == 1) cont = 1'b1; else reset_game = 1'b1;
        repeat (3) @(negedge clk);
        choose = 1'b0; cont = 1'b0; reset_game = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic play(input logic [2:0] a, input logic [2:0] b);
        sw = a;
        press(0);
        sw = b;
        press(0);
    endtask

    function automatic int idx(input logic [2:0] c);
        return (c == 3'b001) ? 0 : (c == 3'b010) ? 1 : 2;
    endfunction

    // cat=0, dog=1, chicken=2: each index beats the one just below it, cyclically.
    function automatic int wins(input int x, input int y);
        return ((x - y + 3) % 3) == 1;
    endfunction

    initial begin
        vec_t tbl[9];
        int inv0, first, e1, e2, s1, s2, i1, i2;
        logic [2:0] code, ca, cb;

        tbl[0] = '{3'b001, 3'b001, 9'b100000000, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{3'b001, 3'b010, 9'b010000000, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{3'b001, 3'b100, 9'b001000000, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{3'b010, 3'b001, 9'b000100000, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{3'b010, 3'b010, 9'b000010000, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{3'b010, 3'b100, 9'b000001000, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{3'b100, 3'b001, 9'b000000100, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{3'b100, 3'b010, 9'b000000010, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{3'b100, 3'b100, 9'b000000001, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_scenario", int'(scenario), 0);
        chk("rst_flags", int'({scenario_valid, winner1, winner2, tie, match_over, invalid, turn}), 0);
        chk("rst_scores", int'({player1, player2}), 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // p1 dog vs p2 cat, with cycle-level timing of the result
        sw = 3'b010;
        press(0);
        chk("p1_commit_turn", int'(turn), 1);
        sw = 3'b001;
        @(negedge clk) choose = 1'b1;
        repeat (3) @(negedge clk);
        chk("resolve_valid_low", int'(scenario_valid), 0);
        chk("resolve_turn", int'(turn), 0);
        choose = 1'b0;
        first = 0;
        for (int c = 4; c < 20; c++) begin
            @(negedge clk);
            if (scenario_valid) begin
                first = c;
                break;
            end
        end
        chk("valid_latency", first, 4);
        chk("dog_cat_scenario", int'(scenario), int'(9'b000100000));
        chk("dog_cat_winner1", int'(winner1), 1);
        chk("dog_cat_player1", int'(player1), 1);
        press(1);
        chk("cont_clears_valid", int'(scenario_valid), 0);
        chk("cont_clears_winner", int'(winner1), 0);

        // rejected commit
        inv0 = inv_cnt;
        sw = 3'b011;
        press(0);
        chk("invalid_pulses", inv_cnt - inv0, 1);
        chk("invalid_turn", int'(turn), 0);
        sw = 3'b100;
        press(0);
        chk("after_invalid_commit", int'(turn), 1);
        press(2);
        chk("rg_turn", int'(turn), 0);
        chk("rg_player1", int'(player1), 0);

        // every pairing from the table
        e1 = 0;
        e2 = 0;
        for (int i = 0; i < 9; i++) begin
            play(tbl[i].a, tbl[i].b);
            e1 += int'(tbl[i].w1);
            e2 += int'(tbl[i].w2);
            chk($sformatf("tbl%0d_scenario", i), int'(scenario), int'(tbl[i].scen));
            chk($sformatf("tbl%0d_flags", i), int'({winner1, winner2, tie}), int'({tbl[i].w1, tbl[i].w2, tbl[i].t}));
            chk($sformatf("tbl%0d_valid", i), int'(scenario_valid), 1);
            chk($sformatf("tbl%0d_p1", i), int'(player1), e1);
            chk($sformatf("tbl%0d_p2", i), int'(player2), e2);
            press(1);
        end

        // choose held for 100 cycles commits once
        press(2);
        inv0 = inv_cnt;
        sw = 3'b001;
        @(negedge clk) choose = 1'b1;
        repeat (100) @(negedge clk);
        choose = 1'b0;
        repeat (5) @(negedge clk);
        chk("hold_turn", int'(turn), 1);
        chk("hold_valid", int'(scenario_valid), 0);
        chk("hold_invalid", inv_cnt - inv0, 0);

        // p2 wins the match
        press(2);
        for (int r = 0; r < 5; r++) begin
            play(3'b001, 3'b010);
            if (r < 4) begin
                chk($sformatf("match_r%0d_over", r), int'(match_over), 0);
                press(1);
            end
        end
        chk("match_player2", int'(player2), 5);
        chk("match_over", int'(match_over), 1);
        chk("match_valid", int'(scenario_valid), 1);
        press(1);
        chk("over_cont_ignored", int'(match_over), 1);
        chk("over_cont_valid", int'(scenario_valid), 1);
        inv0 = inv_cnt;
        sw = 3'b001;
        press(0);
        chk("over_choose_turn", int'(turn), 0);
        chk("over_choose_invalid", inv_cnt - inv0, 0);
        chk("over_player2", int'(player2), 5);

        // reset_game and cont together in SHOW
        press(2);
        play(3'b001, 3'b100);
        chk("show_p1", int'(player1), 1);
        @(negedge clk);
        reset_game = 1'b1;
        cont = 1'b1;
        repeat (3) @(negedge clk);
        reset_game = 1'b0;
        cont = 1'b0;
        repeat (5) @(negedge clk);
        chk("rgc_scores", int'({player1, player2}), 0);
        chk("rgc_valid", int'(scenario_valid), 0);
        sw = 3'b010;
        press(0);
        chk("rgc_wait_p1", int'(turn), 1);

        // asynchronous reset in WAIT_P2
        @(negedge clk) resetn = 1'b0;
        #1;
        chk("areset_turn", int'(turn), 0);
        chk("areset_flags", int'({scenario_valid, winner1, winner2, tie, match_over, invalid}), 0);
        chk("areset_scenario", int'(scenario), 0);
        @(negedge clk) resetn = 1'b1;
        repeat (5) @(negedge clk);

        // reset released while choose is held
        @(negedge clk) begin
            choose = 1'b1;
            resetn = 1'b0;
        end
        @(negedge clk) resetn = 1'b1;
        repeat (10) @(negedge clk);
        chk("held_through_reset", int'(turn), 0);
        choose = 1'b0;
        repeat (4) @(negedge clk);
        sw = 3'b001;
        press(0);
        chk("press_after_release", int'(turn), 1);
        press(2);

        // randomized rounds against the score model
        s1 = 0;
        s2 = 0;
        for (int r = 0; r < 30; r++) begin
            for (int p = 0; p < 2; p++) begin
                code = 3'($urandom_range(0, 7));
                if ($countones(code) != 1) begin
                    inv0 = inv_cnt;
                    sw = code;
                    press(0);
                    chk("rnd_invalid", inv_cnt - inv0, 1);
                    chk("rnd_invalid_turn", int'(turn), p);
                    code = 3'(1 << $urandom_range(0, 2));
                end
                sw = code;
                press(0);
                if (p == 0) ca = code; else cb = code;
            end
            i1 = idx(ca);
            i2 = idx(cb);
            if (wins(i1, i2) != 0 && s1 < 9) s1++;
            if (wins(i2, i1) != 0 && s2 < 9) s2++;
            chk("rnd_scenario", int'(scenario), 1 << (8 - (3 * i1 + i2)));
            chk("rnd_flags", int'({winner1, winner2, tie}), (wins(i1, i2) << 2) | (wins(i2, i1) << 1) | int'(i1 == i2));
            chk("rnd_p1", int'(player1), s1);
            chk("rnd_p2", int'(player2), s2);
            chk("rnd_over", int'(match_over), int'(s1 == WIN || s2 == WIN));
            if (s1 == WIN || s2 == WIN) begin
                press(2);
                s1 = 0;
                s2 = 0;
                chk("rnd_restart", int'({player1, player2}), 0);
            end else begin
                press(1);
                chk("rnd_cont", int'(scenario_valid), 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/choice_arbiter.md
CHOICE_ARBITER -- requirements
Module: choice_arbiter

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 4'd5, meaning the points a player needs to win the match (range 1..9).
REQ-002 SHALL have port clk  input  1  system clock, CLOCK_50 domain.
REQ-003 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port sw  input  3  choice code: 3'b001 cat, 3'b010 dog, 3'b100 chicken.
REQ-005 SHALL have port choose  input  1  asynchronous level, high while the player commits (inverted KEY[2]).
REQ-006 SHALL have port cont  input  1  asynchronous level, high to advance past the result (inverted KEY[1]).
REQ-007 SHALL have port reset_game  input  1  asynchronous level, high to restart the match (inverted KEY[3]).
REQ-008 SHALL have port scenario  output  9  one-hot round outcome, bit (8 - (3*p1idx + p2idx)), idx cat=0 dog=1 chicken=2.
REQ-009 SHALL have port scenario_valid  output  1  scenario and winner flags are meaningful.
REQ-010 SHALL have ports winner1, winner2, tie  output  1 each  round result flags.
REQ-011 SHALL have ports player1, player2  output  4 each  scores, 0..9.
REQ-012 SHALL have port match_over  output  1  a score has reached WIN_SCORE.
REQ-013 SHALL have port invalid  output  1  one-cycle pulse when a commit is rejected.
REQ-014 SHALL have port turn  output  1  0 = awaiting player 1, 1 = awaiting player 2.

Function
REQ-015 SHALL pass choose, cont and reset_game through 2-FF synchronizers, then rising-edge detect (1 pulse per press).
REQ-016 SHALL run FSM states WAIT_P1, WAIT_P2, RESOLVE, SHOW, OVER.
REQ-017 WAIT_P1: on choose edge with one-hot sw, SHALL latch sw as p1 and go to WAIT_P2; on non-one-hot sw, SHALL pulse invalid and stay.
REQ-018 WAIT_P2: on choose edge SHALL apply the same rule, latching p2 and going to RESOLVE.
REQ-019 Dog beats cat, cat beats chicken, chicken beats dog; equal choices are a tie.
REQ-020 RESOLVE (one cycle) SHALL register scenario/winner1/winner2/tie, increment the winner's score, and assert scenario_valid on the next cycle.
REQ-021 Scores SHALL saturate at 9 with no wrap.
REQ-022 After RESOLVE, SHALL go to OVER if the updated score equals WIN_SCORE, else to SHOW.
REQ-023 SHOW: SHALL hold scenario_valid high until a cont edge, then clear scenario_valid and the flags and return to WAIT_P1.
REQ-024 OVER: SHALL hold match_over=1 and scenario_valid=1, and ignore choose and cont.
REQ-025 A reset_game edge in any state SHALL clear scores, flags and latched choices and go to WAIT_P1 on the next cycle, taking priority over a simultaneous choose or cont.
REQ-026 choose edges in SHOW and RESOLVE SHALL be ignored without pulsing invalid.
REQ-027 turn SHALL be 1 only in WAIT_P2.

Reset
REQ-028 resetn low SHALL asynchronously force state WAIT_P1 and scenario=0; all flags, scores, invalid, turn, synchronizers and edge registers SHALL go to 0.
REQ-029 Reset released mid-press SHALL NOT generate an edge until the input has been seen low.

Structure
REQ-030 Choice codes, state encoding and the win table SHALL live in shared package game_pkg.
REQ-031 The synchronizer plus edge detector SHALL be sub-module key_edge, instantiated three times.

Verification
REQ-032 Test: p1 sw=010 commit, p2 sw=001 commit. Expect scenario=9'b000100000, winner1=1, player1=1 and scenario_valid 1 cycle after RESOLVE.
REQ-033 Test: sw=011 commit in WAIT_P1. Expect a single invalid pulse, state unchanged and turn=0.
REQ-034 Test: five rounds in which p2 wins with WIN_SCORE=5. Expect player2=5, match_over=1, and a further cont ignored.
REQ-035 Test: reset_game and cont rising in the same cycle during SHOW. Expect WAIT_P1 with scores 0.
REQ-036 Test: resetn pulsed low in WAIT_P2. Expect immediate WAIT_P1 and all outputs 0.
REQ-037 Test: choose held high for 100 cycles. Expect exactly one commit.
